// File: rtl/dec_half_sel_burst.sv
// dec_half_sel_burst: accepts an operand and emits a burst of its successive decrements, narrowed to one half.
module dec_half_sel_burst #(
    parameter int W = 3,
    parameter int LW = 4,
    localparam int ZW = W + 1,
    localparam int OW = (ZW + 1) / 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic          in_sel,
    input  logic [LW-1:0] in_len,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_data,
    output logic          out_last,
    output logic          out_wrap,
    output logic          busy
);
    // Wide enough for both the decrement word and the beat index k+1.
    localparam int DW = (ZW > LW + 1) ? ZW : LW + 1;
    typedef enum logic {S_IDLE, S_RUN} state_t;
    state_t r_state, w_next;
    logic [LW-1:0] r_cnt, r_len;
    logic [W-1:0]  r_a;
    logic          r_sel;
    logic [DW-1:0] w_k1, w_ext, w_diff;
    logic [ZW-1:0] w_z;
    logic          w_last, w_hs, w_acc;
    assign w_k1   = DW'(r_cnt) + DW'(1);
    assign w_ext  = DW'(r_a);
    assign w_diff = w_ext - w_k1;
    assign w_z    = w_diff[ZW-1:0];
    assign w_last = r_cnt == r_len;
    assign w_hs   = out_valid && out_ready;
    assign w_acc  = in_valid && in_ready;
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_a   <= '0;
            r_sel <= 1'b0;
            r_len <= '0;
        end else if (w_acc) begin
            r_cnt <= '0;
            r_a   <= in_a;
            r_sel <= in_sel;
            r_len <= in_len;
        end else if (w_hs && !w_last) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
    always_comb begin
        w_next = r_state;
        if (r_state == S_IDLE) w_next = w_acc ? S_RUN : S_IDLE;
        else if (w_hs && w_last) w_next = w_acc ? S_RUN : S_IDLE;
    end
    // Data outputs are forced to zero whenever no beat is presented.
    always_comb begin
        out_valid = r_state == S_RUN;
        busy      = r_state == S_RUN;
        in_ready  = (r_state == S_IDLE) || (out_valid && out_ready && out_last);
        out_data  = !out_valid ? '0 : r_sel ? w_z[OW-1:0] : w_z[ZW-1:ZW-OW];
        out_last  = out_valid && w_last;
        out_wrap  = out_valid && (w_ext < w_k1);
    end
endmodule
